gate_bist: RTL and testbench

- Parametrised built-in self-test engine for small N-input logic gates.
- Sweeps all 2^N_IN input combinations into a device under test and waits a programmable settle time per vector.
- Samples the DUT output and compares it against a selectable reference gate function.
- Reports pass/fail, a saturating error count and the first failing vector. Sits beside the gate under test and replaces hand-written truth-table stimulus.

---
 rtl/gate_bist_pkg.sv | 46 ++++
 rtl/gate_bist_gate_ref_model.sv | 14 +
 rtl/gate_bist.sv | 161 ++++++++++++++++
 tb/tb_gate_bist.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared encodings and the reference gate function for the gate BIST engine.
package gate_bist_pkg;

   localparam int unsigned MODE_W    = 3;
   localparam int unsigned VEC_MAX_W = 8;

   localparam logic [MODE_W-1:0] MODE_AND  = 3'd0;
   localparam logic [MODE_W-1:0] MODE_OR   = 3'd1;
   localparam logic [MODE_W-1:0] MODE_XOR  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_NAND = 3'd3;
   localparam logic [MODE_W-1:0] MODE_NOR  = 3'd4;
   localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Expected gate output for the low n_in bits of vec; modes 6/7 give constant 0.
   function automatic logic ref_gate(input logic [MODE_W-1:0]    mode,
                                     input logic [VEC_MAX_W-1:0] vec,
                                     input int unsigned          n_in);
      logic [VEC_MAX_W-1:0] mask;
      logic                 red_and;
      logic                 red_or;
      logic                 red_xor;
      logic                 res;
      mask    = VEC_MAX_W'((16'(1) << n_in) - 16'(1));
      red_and = &(vec | ~mask);
      red_or  = |(vec & mask);
      red_xor = ^(vec & mask);
      case (mode)
         MODE_AND:  res = red_and;
         MODE_OR:   res = red_or;
         MODE_XOR:  res = red_xor;
         MODE_NAND: res = ~red_and;
         MODE_NOR:  res = ~red_or;
         MODE_XNOR: res = ~red_xor;
         default:   res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/gate_bist_gate_ref_model.sv
// Combinational reference gate: expected DUT output for the current vector.
module gate_ref_model
   import gate_bist_pkg::*;
#(
   parameter int unsigned N_IN = 2
) (
   input  logic [MODE_W-1:0] i_mode,
   input  logic [N_IN-1:0]   i_vec,
   output logic              o_exp_c
);

   assign o_exp_c = ref_gate(i_mode, VEC_MAX_W'(i_vec), N_IN);

endmodule

// File: rtl/gate_bist.sv
// Exhaustive truth-table BIST for a small N-input gate with settle/sample pacing.
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [MODE_W-1:0] mode,
   output logic [N_IN-1:0]   stim,
   input  logic              dut_y,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [N_IN-1:0]   first_fail,
   output logic              first_fail_vld
);

   localparam int unsigned       CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(SETTLE - 1);

   state_t              r_state, w_state_nxt;
   logic [MODE_W-1:0]   r_mode, w_mode_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [N_IN-1:0]     r_stim, w_stim_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;
   logic                r_pass, w_pass_nxt;
   logic [ERR_W-1:0]    r_err, w_err_nxt;
   logic [N_IN-1:0]     r_ff, w_ff_nxt;
   logic                r_ffv, w_ffv_nxt;
   logic                w_exp;
   logic                w_mismatch;
   logic [ERR_W-1:0]    w_err_inc;

   gate_ref_model #(.N_IN(N_IN)) u_ref (
      .i_mode  (r_mode),
      .i_vec   (r_stim),
      .o_exp_c (w_exp)
   );

   assign w_mismatch = (dut_y != w_exp);
   assign w_err_inc  = (r_err == '1) ? r_err : r_err + ERR_W'(1);

   // Next-state and next-value logic for the sweep sequencer.
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_cnt_nxt   = r_cnt;
      w_stim_nxt  = r_stim;
      w_busy_nxt  = r_busy;
      w_done_nxt  = r_done;
      w_pass_nxt  = r_pass;
      w_err_nxt   = r_err;
      w_ff_nxt    = r_ff;
      w_ffv_nxt   = r_ffv;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt = ST_SETTLE;
               w_mode_nxt  = mode;
               w_cnt_nxt   = RELOAD;
               w_stim_nxt  = '0;
               w_busy_nxt  = 1'b1;
               w_done_nxt  = 1'b0;
               w_pass_nxt  = 1'b0;
               w_err_nxt   = '0;
               w_ff_nxt    = '0;
               w_ffv_nxt   = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b0;
               w_pass_nxt  = 1'b0;
               w_stim_nxt  = '0;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_SAMPLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b0;
               w_pass_nxt  = 1'b0;
               w_stim_nxt  = '0;
            end else begin
               if (w_mismatch) begin
                  w_err_nxt = w_err_inc;
                  if (!r_ffv) begin
                     w_ff_nxt  = r_stim;
                     w_ffv_nxt = 1'b1;
                  end
               end
               if (r_stim == '1) begin
                  w_state_nxt = ST_DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  // A mismatch on the last vector always leaves a non-zero count.
                  w_pass_nxt  = !w_mismatch && (r_err == '0);
               end else begin
                  w_state_nxt = ST_SETTLE;
                  w_stim_nxt  = r_stim + N_IN'(1);
                  w_cnt_nxt   = RELOAD;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= '0;
         r_cnt  <= '0;
         r_stim <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
         r_err  <= '0;
         r_ff   <= '0;
         r_ffv  <= 1'b0;
      end else begin
         r_mode <= w_mode_nxt;
         r_cnt  <= w_cnt_nxt;
         r_stim <= w_stim_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_pass <= w_pass_nxt;
         r_err  <= w_err_nxt;
         r_ff   <= w_ff_nxt;
         r_ffv  <= w_ffv_nxt;
      end
   end

   assign stim           = r_stim;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err;
   assign first_fail     = r_ff;
   assign first_fail_vld = r_ffv;

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: three configurations against a truth-table model.
module tb_gate_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start_v [3];
   logic         abort_v [3];
   logic [2:0]   mode_v  [3];
   logic [255:0] tbl_v   [3];

   logic [1:0] stim0, ff0;
   logic [2:0] stim1, ff1, stim2, ff2;
   logic [7:0] err0, err1;
   logic [1:0] err2;
   logic busy0, done0, pass0, ffv0;
   logic busy1, done1, pass1, ffv1;
   logic busy2, done2, pass2, ffv2;
   logic dy0, dy1, dy2;

   // Device under test modelled as a lookup table indexed by the applied vector.
   assign dy0 = tbl_v[0][stim0];
   assign dy1 = tbl_v[1][stim1];
   assign dy2 = tbl_v[2][stim2];

   gate_bist #(.N_IN(2), .SETTLE(1), .ERR_W(8)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .mode(mode_v[0]),
      .stim(stim0), .dut_y(dy0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .first_fail(ff0), .first_fail_vld(ffv0));

   gate_bist #(.N_IN(3), .SETTLE(2), .ERR_W(8)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .mode(mode_v[1]),
      .stim(stim1), .dut_y(dy1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_fail(ff1), .first_fail_vld(ffv1));

   gate_bist #(.N_IN(3), .SETTLE(1), .ERR_W(2)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .mode(mode_v[2]),
      .stim(stim2), .dut_y(dy2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_fail(ff2), .first_fail_vld(ffv2));

   int n_chk  = 0;
   int n_fail = 0;

   function automatic int n_of(input int k);
      return (k == 0) ? 2 : 3;
   endfunction
   function automatic int s_of(input int k);
      return (k == 1) ? 2 : 1;
   endfunction
   function automatic int ew_of(input int k);
      return (k == 2) ? 2 : 8;
   endfunction

   // Gate truth from the count of ones among the n inputs.
   function automatic logic model_ref(input int mode, input int v, input int n);
      int ones;
      ones = $countones(v);
      case (mode)
         0: return ones == n;
         1: return ones > 0;
         2: return (ones % 2) == 1;
         3: return ones != n;
         4: return ones == 0;
         5: return (ones % 2) == 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic get(input int k, output int st, output logic bz, output logic dn,
                      output logic ps, output int er, output int ff, output logic fv);
      case (k)
         0: begin st = int'(stim0); bz = busy0; dn = done0; ps = pass0;
                  er = int'(err0); ff = int'(ff0); fv = ffv0; end
         1: begin st = int'(stim1); bz = busy1; dn = done1; ps = pass1;
                  er = int'(err1); ff = int'(ff1); fv = ffv1; end
         default: begin st = int'(stim2); bz = busy2; dn = done2; ps = pass2;
                  er = int'(err2); ff = int'(ff2); fv = ffv2; end
      endcase
   endtask

   // kind: 0 correct gate of mode, 1 gate of mode gm, 2 stuck-at-1, 3 stuck-at-0, 4 random flips.
   task automatic set_tbl(input int k, input int kind, input int mode, input int gm);
      logic [255:0] t;
      t = '0;
      for (int v = 0; v < (1 << n_of(k)); v++) begin
         case (kind)
            0: t[v] = model_ref(mode, v, n_of(k));
            1: t[v] = model_ref(gm, v, n_of(k));
            2: t[v] = 1'b1;
            3: t[v] = 1'b0;
            default: t[v] = model_ref(mode, v, n_of(k)) ^ ($urandom_range(3) == 0);
         endcase
      end
      tbl_v[k] = t;
   endtask

   // Expected result after sampling vectors 0..nv-1.
   task automatic model_sweep(input int k, input int mode, input int nv,
                              output int e_err, output int e_ff, output logic e_fv);
      int sat;
      e_err = 0; e_ff = 0; e_fv = 1'b0;
      sat = (1 << ew_of(k)) - 1;
      for (int v = 0; v < nv; v++) begin
         if (tbl_v[k][v] !== model_ref(mode, v, n_of(k))) begin
            if (!e_fv) begin e_ff = v; e_fv = 1'b1; end
            e_err++;
         end
      end
      if (e_err > sat) e_err = sat;
   endtask

   // Full sweep with cycle-exact stim/busy/done timeline and final result check.
   task automatic run_sweep(input int k, input int mode, input bit noise);
      int n, s, len, e_err, e_ff, st, er, ff;
      logic e_fv, bz, dn, ps, fv;
      n = n_of(k); s = s_of(k); len = (1 << n) * (s + 1);
      model_sweep(k, mode, 1 << n, e_err, e_ff, e_fv);
      mode_v[k] = 3'(mode); start_v[k] = 1'b1;
      tick();
      start_v[k] = 1'b0;
      for (int c = 1; c <= len; c++) begin
         get(k, st, bz, dn, ps, er, ff, fv);
         n_chk++;
         if ({st, bz, dn} !== {(c - 1) / (s + 1), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sweep_timeline k=%0d c=%0d: stim=%0d busy=%b done=%b, want stim=%0d busy=1 done=0",
                     k, c, st, bz, dn, (c - 1) / (s + 1));
         end
         if (noise) begin
            mode_v[k]  = 3'($urandom_range(7));
            start_v[k] = ($urandom_range(3) == 0);
         end
         tick();
      end
      start_v[k] = 1'b0;
      for (int h = 0; h < 2; h++) begin
         get(k, st, bz, dn, ps, er, ff, fv);
         n_chk++;
         if ({bz, dn, ps, er, ff, fv} !== {1'b0, 1'b1, (e_err == 0), e_err, e_ff, e_fv}) begin
            n_fail++;
            $display("FAIL sweep_result k=%0d mode=%0d h=%0d: busy=%b done=%b pass=%b err=%0d ff=%0d fv=%b, want 0 1 %b %0d %0d %b",
                     k, mode, h, bz, dn, ps, er, ff, fv, (e_err == 0), e_err, e_ff, e_fv);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      int st, er, ff;
      logic bz, dn, ps, fv;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start_v[k] = 1'b0; abort_v[k] = 1'b0; mode_v[k] = 3'd0; tbl_v[k] = '0;
      end
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         get(k, st, bz, dn, ps, er, ff, fv);
         n_chk++;
         if ({st, bz, dn, ps, er, ff, fv} !== {32'd0, 3'b000, 32'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values k=%0d: stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d fv=%b, want all 0",
                     k, st, bz, dn, ps, er, ff, fv);
         end
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_plan_configs();
      set_tbl(0, 0, 0, 0); run_sweep(0, 0, 1'b0);        // AND, correct DUT
      set_tbl(0, 1, 0, 1); run_sweep(0, 0, 1'b0);        // AND expected, OR DUT
      n_chk++;
      if ({err0, ff0, ffv0, pass0} !== {8'd2, 2'b01, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL or_dut_plan: err=%0d ff=%0d fv=%b pass=%b, want 2 1 1 0", err0, ff0, ffv0, pass0);
      end
      set_tbl(1, 2, 2, 0); run_sweep(1, 2, 1'b0);        // XOR, stuck-at-1
      n_chk++;
      if ({err1, ff1} !== {8'd4, 3'd0}) begin
         n_fail++;
         $display("FAIL xor_stuck1_plan: err=%0d ff=%0d, want 4 0", err1, ff1);
      end
      set_tbl(2, 2, 4, 0); run_sweep(2, 4, 1'b0);        // NOR, stuck-at-1, saturating
      n_chk++;
      if ({err2, pass2} !== {2'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL nor_saturate_plan: err=%0d pass=%b, want 3 0", err2, pass2);
      end
   endtask

   task automatic test_random();
      int md, kd;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 3; k++) begin
            md = int'($urandom_range(7));
            kd = int'($urandom_range(4));
            set_tbl(k, kd, md, int'($urandom_range(5)));
            run_sweep(k, md, 1'b1);
         end
      end
   endtask

   task automatic test_abort();
      int st, er, ff, s, c_ab, e_err, e_ff;
      logic bz, dn, ps, fv, e_fv;
      // Fixed scenario: start ignored at cycle 2, abort at cycle 4.
      set_tbl(0, 4, 1, 0); mode_v[0] = 3'd1; start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         get(0, st, bz, dn, ps, er, ff, fv);
         n_chk++;
         if ({st, bz} !== {(c - 1) / 2, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_pre k=0 c=%0d: stim=%0d busy=%b, want %0d 1", c, st, bz, (c - 1) / 2);
         end
         start_v[0] = (c == 2);
         abort_v[0] = (c == 4);
         tick();
      end
      start_v[0] = 1'b0; abort_v[0] = 1'b0;
      get(0, st, bz, dn, ps, er, ff, fv);
      n_chk++;
      if ({st, bz, dn, ps} !== {32'd0, 3'b000}) begin
         n_fail++;
         $display("FAIL abort_cycle5: stim=%0d busy=%b done=%b pass=%b, want 0 0 0 0", st, bz, dn, ps);
      end
      // Random abort during a settle cycle keeps partial error results.
      for (int i = 0; i < 4; i++) begin
         s = s_of(1);
         set_tbl(1, 4, 5, 0); mode_v[1] = 3'd5;
         do c_ab = int'($urandom_range(24, 1)); while (((c_ab - 1) % (s + 1)) >= s);
         model_sweep(1, 5, (c_ab - 1) / (s + 1), e_err, e_ff, e_fv);
         start_v[1] = 1'b1;
         tick();
         start_v[1] = 1'b0;
         for (int c = 1; c <= c_ab; c++) begin
            abort_v[1] = (c == c_ab);
            tick();
         end
         abort_v[1] = 1'b0;
         for (int h = 0; h < 2; h++) begin
            get(1, st, bz, dn, ps, er, ff, fv);
            n_chk++;
            if ({st, bz, dn, ps, er, ff, fv} !== {32'd0, 3'b000, e_err, e_ff, e_fv}) begin
               n_fail++;
               $display("FAIL abort_partial c=%0d h=%0d: stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d fv=%b, want 0 0 0 0 %0d %0d %b",
                        c_ab, h, st, bz, dn, ps, er, ff, fv, e_err, e_ff, e_fv);
            end
            tick();
         end
      end
   endtask

   task automatic test_idle_controls_and_reset();
      int st, er, ff, e_err, e_ff;
      logic bz, dn, ps, fv, e_fv;
      // Abort in DONE has no effect.
      set_tbl(2, 2, 0, 0); run_sweep(2, 0, 1'b0);
      model_sweep(2, 0, 8, e_err, e_ff, e_fv);
      abort_v[2] = 1'b1; tick(); abort_v[2] = 1'b0;
      get(2, st, bz, dn, ps, er, ff, fv);
      n_chk++;
      if ({bz, dn, er, ff, fv} !== {1'b0, 1'b1, e_err, e_ff, e_fv}) begin
         n_fail++;
         $display("FAIL abort_in_done: busy=%b done=%b err=%0d ff=%0d fv=%b, want 0 1 %0d %0d %b",
                  bz, dn, er, ff, fv, e_err, e_ff, e_fv);
      end
      // Start and abort together when not busy: start wins (cycle 0).
      set_tbl(0, 0, 3, 0); mode_v[0] = 3'd3;
      start_v[0] = 1'b1; abort_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0; abort_v[0] = 1'b0;
      get(0, st, bz, dn, ps, er, ff, fv);
      n_chk++;
      if ({st, bz, dn} !== {32'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL start_beats_abort: stim=%0d busy=%b done=%b, want 0 1 0", st, bz, dn);
      end
      // Reset asserted at cycle 6 of this sweep.
      for (int c = 1; c <= 6; c++) begin
         rst = (c == 6);
         tick();
      end
      rst = 1'b0;
      get(0, st, bz, dn, ps, er, ff, fv);
      n_chk++;
      if ({st, bz, dn, ps, er, ff, fv} !== {32'd0, 3'b000, 32'd0, 32'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_sweep: stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d fv=%b, want all 0",
                  st, bz, dn, ps, er, ff, fv);
      end
      run_sweep(0, 3, 1'b0);
      n_chk++;
      if (pass0 !== 1'b1) begin
         n_fail++;
         $display("FAIL pass_after_reset: pass=%b, want 1", pass0);
      end
   endtask

   initial begin
      test_reset();
      test_plan_configs();
      test_random();
      test_abort();
      test_idle_controls_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
